// File: rtl/pattern_tx_if.sv
// Request/serial-stream bundle between a pattern_tx and whatever drives and consumes it.
interface pattern_tx_if #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic             use_default;
  logic [W-1:0]     pat_in;
  logic [CNT_W-1:0] repeat_n;
  logic             bit_out;
  logic             bit_valid;
  logic             busy;
  logic             frame_done;
  logic             done;

  modport master (
    output start, use_default, pat_in, repeat_n,
    input  bit_out, bit_valid, busy, frame_done, done
  );

  modport slave (
    input  start, use_default, pat_in, repeat_n,
    output bit_out, bit_valid, busy, frame_done, done
  );
endinterface

// File: rtl/pattern_tx.sv
// Serial bit-pattern generator: shifts a W-bit pattern out MSB-first for N frames,
// with GAP idle cycles between frames. All outputs registered.
module pattern_tx #(
  parameter int unsigned    W           = 4,
  parameter logic [W-1:0]   DEFAULT_PAT = W'(4'b1011),
  parameter int unsigned    GAP         = 2,
  parameter int unsigned    CNT_W       = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  pattern_tx_if.slave    bus
);
  localparam int unsigned IDX_W = $clog2(W);
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [W-1:0]     pat_q, pat_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             bit_out_q, bit_out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             fdone_q, fdone_d;
  logic             done_q, done_d;
  logic [W-1:0]     sel_pat;
  logic             last_bit;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      pat_q     <= '0;
      frames_q  <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      bit_out_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      fdone_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      pat_q     <= pat_d;
      frames_q  <= frames_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      bit_out_q <= bit_out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      fdone_q   <= fdone_d;
      done_q    <= done_d;
    end
  end

  // Next state; output next-values describe the cycle after the coming edge
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    pat_d     = pat_q;
    frames_d  = frames_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    bit_out_d = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    fdone_d   = 1'b0;
    done_d    = 1'b0;
    sel_pat   = bus.use_default ? DEFAULT_PAT : bus.pat_in;
    last_bit  = (idx_q == IDX_W'(W - 1));

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          pat_d     = sel_pat;
          shreg_d   = sel_pat;
          frames_d  = (bus.repeat_n == '0) ? CNT_W'(1) : bus.repeat_n;
          idx_d     = '0;
          bit_out_d = sel_pat[W-1];
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (!last_bit) begin
          shreg_d   = shreg_q << 1;
          idx_d     = idx_q + IDX_W'(1);
          bit_out_d = shreg_q[W-2];
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          fdone_d   = (idx_q == IDX_W'(W - 2));
        end else if (frames_q > CNT_W'(1)) begin
          frames_d = frames_q - CNT_W'(1);
          busy_d   = 1'b1;
          if (GAP > 0) begin
            gap_d   = '0;
            state_d = ST_GAP;
          end else begin
            // Back-to-back frames: restart from the saved pattern with no bubble
            shreg_d   = pat_q;
            idx_d     = '0;
            bit_out_d = pat_q[W-1];
            valid_d   = 1'b1;
          end
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_GAP: begin
        busy_d = 1'b1;
        if (gap_q == GAP_W'(GAP - 1)) begin
          shreg_d   = pat_q;
          idx_d     = '0;
          bit_out_d = pat_q[W-1];
          valid_d   = 1'b1;
          state_d   = ST_SHIFT;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.bit_out    = bit_out_q;
  assign bus.bit_valid  = valid_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = fdone_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: two instances (GAP=2 and GAP=0) checked cycle by
// cycle against an expected output stream built from the frame/gap rules.
module tb_pattern_tx;
  localparam int unsigned W     = 4;
  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pattern_tx_if #(.W(W), .CNT_W(CNT_W)) bus0 ();
  pattern_tx_if #(.W(W), .CNT_W(CNT_W)) bus1 ();

  pattern_tx #(.W(W), .DEFAULT_PAT(4'b1011), .GAP(2), .CNT_W(CNT_W)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  pattern_tx #(.W(W), .DEFAULT_PAT(4'b1011), .GAP(0), .CNT_W(CNT_W)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  int total = 0;
  int passed = 0;
  int txn_id = 0;
  int det_hits = 0;
  int det_seen = 0;
  logic [3:0] det_hist = 4'b0000;

  // Observation vector: {bit_out, bit_valid, busy, frame_done, done}
  function automatic logic [4:0] obs(input int sel);
    if (sel == 0) return {bus0.bit_out, bus0.bit_valid, bus0.busy, bus0.frame_done, bus0.done};
    return {bus1.bit_out, bus1.bit_valid, bus1.busy, bus1.frame_done, bus1.done};
  endfunction

  task automatic check(input string tag, input logic [4:0] o, input logic [4:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed {out,valid,busy,fdone,done}=%b expected=%b", tag, o, e);
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
  endtask

  task automatic set_in(input int sel, input bit st, input bit ud,
                        input logic [3:0] pat, input logic [3:0] rep);
    if (sel == 0) begin
      bus0.start = st; bus0.use_default = ud; bus0.pat_in = pat; bus0.repeat_n = rep;
    end else begin
      bus1.start = st; bus1.use_default = ud; bus1.pat_in = pat; bus1.repeat_n = rep;
    end
  endtask

  // Run one transfer whose start is already on the inputs. hold keeps start high and
  // scrambles the other inputs mid-transfer; chain loads the next request in the done cycle.
  task automatic run(input int sel, input bit ud, input logic [3:0] pat, input logic [3:0] rep,
                     input bit hold, input bit chain,
                     input bit c_ud, input logic [3:0] c_pat, input logic [3:0] c_rep);
    logic [4:0] exp_q[$];
    logic [3:0] pe;
    logic [4:0] o;
    int n, gap;
    pe  = ud ? 4'b1011 : pat;
    n   = (rep == 0) ? 1 : int'(rep);
    gap = (sel == 0) ? 2 : 0;
    for (int f = 0; f < n; f++) begin
      for (int i = 0; i < 4; i++)
        exp_q.push_back({pe[3-i], 1'b1, 1'b1, (i == 3), 1'b0});
      if (f < n - 1)
        for (int g = 0; g < gap; g++) exp_q.push_back(5'b00100);
    end
    exp_q.push_back(5'b00001);
    txn_id++;
    @(posedge clk); #1;
    for (int k = 0; k < exp_q.size(); k++) begin
      o = obs(sel);
      check($sformatf("txn%0d_cyc%0d", txn_id, k), o, exp_q[k]);
      if (sel == 1 && o[3]) begin
        det_hist = {det_hist[2:0], o[4]};
        det_seen++;
        if (det_seen >= 4 && det_hist == 4'b1011) det_hits++;
      end
      if (k < exp_q.size() - 1) begin
        if (hold) set_in(sel, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)));
        else      set_in(sel, 1'b0, ud, pat, rep);
        @(posedge clk); #1;
      end else if (chain) begin
        set_in(sel, 1'b1, c_ud, c_pat, c_rep);
      end else begin
        set_in(sel, 1'b0, 1'b0, 4'h0, 4'h0);
      end
    end
  endtask

  initial begin
    int sel;
    bit ud, hold;
    logic [3:0] pat, rep;

    rst_n = 1'b0;
    set_in(0, 1'b0, 1'b0, 4'h0, 4'h0);
    set_in(1, 1'b0, 1'b0, 4'h0, 4'h0);
    #3;
    check("reset_u0", obs(0), 5'b00000);
    check("reset_u1", obs(1), 5'b00000);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Default pattern, single frame
    set_in(0, 1'b1, 1'b1, 4'h0, 4'd1);
    run(0, 1'b1, 4'h0, 4'd1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

    // 0110 x3 with 2-cycle gaps
    set_in(0, 1'b1, 1'b0, 4'b0110, 4'd3);
    run(0, 1'b0, 4'b0110, 4'd3, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

    // repeat_n=0 sends one frame
    set_in(0, 1'b1, 1'b0, 4'b1001, 4'd0);
    run(0, 1'b0, 4'b1001, 4'd0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

    // start held high, inputs scrambled mid-transfer, next transfer right after done
    set_in(0, 1'b1, 1'b0, 4'b0110, 4'd2);
    run(0, 1'b0, 4'b0110, 4'd2, 1'b1, 1'b1, 1'b0, 4'b1001, 4'd1);
    run(0, 1'b0, 4'b1001, 4'd1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);

    // Reset during the 2nd bit aborts at once; next start resends from MSB
    set_in(0, 1'b1, 1'b0, 4'b1100, 4'd1);
    @(posedge clk); #1;
    check("abort_bit0", obs(0), 5'b11100);
    set_in(0, 1'b0, 1'b0, 4'b1100, 4'd1);
    @(posedge clk); #1;
    check("abort_bit1", obs(0), 5'b11100);
    #2 rst_n = 1'b0;
    #1 check("abort_reset", obs(0), 5'b00000);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_idle", obs(0), 5'b00000);
    set_in(0, 1'b1, 1'b0, 4'b1100, 4'd1);
    run(0, 1'b0, 4'b1100, 4'd1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

    // GAP=0: continuous 10111011, detector sees two hits
    det_hits = 0; det_seen = 0; det_hist = 4'b0000;
    set_in(1, 1'b1, 1'b1, 4'h0, 4'd2);
    run(1, 1'b1, 4'h0, 4'd2, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    check_int("detector_hits", det_hits, 2);

    // Randomized transfers on both instances
    for (int t = 0; t < 10; t++) begin
      sel  = int'($urandom_range(0, 1));
      ud   = 1'($urandom_range(0, 1));
      pat  = 4'($urandom_range(0, 15));
      rep  = 4'($urandom_range(0, 4));
      hold = 1'($urandom_range(0, 1));
      set_in(sel, 1'b1, ud, pat, rep);
      run(sel, ud, pat, rep, hold, 1'b0, 1'b0, 4'h0, 4'h0);
    end

    @(posedge clk); #1;
    check("final_idle_u0", obs(0), 5'b00000);
    check("final_idle_u1", obs(1), 5'b00000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
